seg7_scan: RTL and testbench
============================

// Module: seg7_scan
// PURPOSE
//   Time-multiplexed controller for a 4-digit common-anode 7-segment display.
//   Latches a 16-bit hex value, scans nibbles onto one shared seg7 decoder (nibble zero-extended to 16 bits).
//   Drives one-hot active-low anodes with an anti-ghosting guard interval.
//   Value updates are deferred to frame boundaries to prevent tearing; sits between CPU debug/IO regs and board pins.
// PARAMETERS
//   DIV    8'd50000-class, default 50000 : clocks per digit slot (DIV >= 2)
//   GUARD  default 2     : leading cycles of each slot with all anodes off (1 <= GUARD < DIV)
//   LZB    default 1     : 1 = blank leading-zero digits 3..1; 0 = show all digits
// PORTS
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous active-high reset
//   in     in   16  value to display; digit i shows in[4i+3:4i], digit 0 = LSN
//   load   in   1   strobe: capture in into shadow register
//   dp     in   4   decimal-point request per digit, active-high
//   blank  in   1   1 = force all anodes off (scan keeps running)
//   seg    out  7   segments gfedcba, active-low, registered
//   dp_n   out  1   decimal point, active-low, registered
//   an     out  4   anode enables, active-low one-hot, registered
//   ack    out  1   one-cycle pulse: shadow value committed to display
//   frame  out  1   one-cycle pulse at start of digit-0 slot
// BEHAVIOUR
//   Reset (async, immediate): seg=7'h7F, dp_n=1, an=4'hF, ack=0, frame=0; shadow=disp=0, pending=0,
//     digit=0, cnt=0, state=GUARD. First clock after release = slot 0, cnt 0.
//   Prescaler cnt counts 0..DIV-1 per slot; at DIV-1 wraps to 0 and digit increments mod 4 (3 -> 0).
//   FSM per slot: GUARD (cnt < GUARD): an=4'hF, seg=7'h7F, dp_n=1.
//     DRIVE (cnt >= GUARD): an = ~(1<<digit), seg = seg7(disp nibble), dp_n = ~dp[digit].
//     GUARD -> DRIVE when cnt reaches GUARD; DRIVE -> GUARD on slot wrap.
//   Outputs registered: values for cnt=k appear one clock later; an low exactly DIV-GUARD cycles/slot.
//   Never more than one anode low in any cycle; an=4'hF for >= GUARD cycles between any two digits.
//   Load: load=1 -> shadow<=in, pending<=1. Multiple loads before a boundary: last one wins, one ack.
//   Frame boundary = cycle where digit 3 slot wraps to digit 0: disp <= (load ? in : shadow);
//     if (pending|load): ack=1, pending<=0. frame=1 on that same cycle regardless.
//   Load coincident with boundary: that in is displayed in the starting frame (bypass), shadow also updated.
//   LZB=1: digit i (i=1..3) blanked (its anode held high during DRIVE, seg=7'h7F) when disp[15:4i]==0.
//     Digit 0 never blanked; disp=0 shows "0" on digit 0.
//   blank=1: an forced 4'hF, seg=7'h7F, dp_n=1 from next clock; cnt/digit/disp/ack keep running.
//   Reset mid-slot: all outputs off immediately, displayed value reverts to 0, pending load lost.
// TESTING  (DIV=8, GUARD=2, LZB=1 unless noted)
//   Reset asserted mid-DRIVE -> same cycle an=4'hF, seg=7'h7F, dp_n=1; after release first an=4'hE
//     with seg=7'h40 ("0") 3 clocks later (cnt=GUARD plus output register).
//   load in=16'h1234 -> ack at next boundary; frame period 32 clk; an 4'hE/seg 7'h19, 4'hD/7'h30,
//     4'hB/7'h24, 4'h7/7'h79; each slot 2 cycles an=4'hF then 6 cycles one-hot low.
//   in=16'h0005 -> digits 3..1 anodes stay high; digit 0 seg=7'h12. LZB=0 -> digit 3 seg=7'h40.
//   load 16'h1111 then 16'h2222 in same frame -> single ack, display 2222 (seg=7'h24 all digits);
//     load 16'hABCD on boundary cycle -> ack same cycle, digit 0 seg=7'h21 in that frame.
//   dp=4'b0100 -> dp_n low only during digit-2 DRIVE; blank=1 -> an=4'hF throughout, frame still
//     pulses every 32 clk; deassert -> scan resumes at current digit.
//   Random load/blank/dp over 10k cycles: checker asserts $onehot0(~an), guard gap >= 2, ack only with frame.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bus between a CPU-side register block and the 7-segment scan controller:
// value/strobe/decimal-point/blank requests in, pin-level drive and status pulses out.
interface seg7_scan_if;
   logic [15:0] in;
   logic        load;
   logic [3:0]  dp;
   logic        blank;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  an;
   logic        ack;
   logic        frame;

   modport master (output in, load, dp, blank,
                   input  seg, dp_n, an, ack, frame);
   modport slave  (input  in, load, dp, blank,
                   output seg, dp_n, an, ack, frame);
endinterface

// File: rtl/seg7_scan.sv
// 4-digit common-anode 7-segment scanner: one shared decoder, guard interval
// with all anodes off at the start of every slot, value updates only at frame boundaries.
module seg7_scan #(
   parameter int DIV   = 50000,
   parameter int GUARD = 2,
   parameter int LZB   = 1
) (
   input logic         clk,
   input logic         rst,
   seg7_scan_if.slave  bus
);
   localparam int CW = $clog2(DIV);
   localparam logic [0:0] ST_GUARD = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    digit;
   logic [0:0]    state;
   logic [15:0]   shadow, disp;
   logic          pending;
   logic [3:0]    lzb_mask;
   logic [3:0]    nib;
   logic          slot_end, boundary, off;
   logic [6:0]    seg_r;
   logic          dpn_r, ack_r, frame_r;
   logic [3:0]    an_r;

   function automatic logic [6:0] seg7(input logic [15:0] v);
      case (v)
         16'h0: return 7'h40;
         16'h1: return 7'h79;
         16'h2: return 7'h24;
         16'h3: return 7'h30;
         16'h4: return 7'h19;
         16'h5: return 7'h12;
         16'h6: return 7'h02;
         16'h7: return 7'h78;
         16'h8: return 7'h00;
         16'h9: return 7'h10;
         16'hA: return 7'h08;
         16'hB: return 7'h03;
         16'hC: return 7'h46;
         16'hD: return 7'h21;
         16'hE: return 7'h06;
         16'hF: return 7'h0E;
         default: return 7'h7F;
      endcase
   endfunction

   assign slot_end = (cnt == CW'(DIV - 1));
   assign boundary = slot_end && (digit == 2'd3);
   assign cnt_nxt  = slot_end ? '0 : cnt + 1'b1;
   assign nib      = disp[4*digit +: 4];

   // A digit is a leading zero when every nibble from it upward is zero.
   assign lzb_mask[0] = 1'b0;
   for (genvar i = 1; i < 4; i++) begin : g_lzb
      assign lzb_mask[i] = (LZB != 0) && (disp[15:4*i] == '0);
   end

   assign off = (state == ST_GUARD) || bus.blank || lzb_mask[digit];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         digit   <= 2'd0;
         state   <= ST_GUARD;
         shadow  <= '0;
         disp    <= '0;
         pending <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (slot_end) begin
            digit <= digit + 2'd1;
            state <= ST_GUARD;
         end else if (cnt_nxt == CW'(GUARD)) begin
            state <= ST_DRIVE;
         end
         if (bus.load) shadow <= bus.in;
         // A load on the boundary itself bypasses the shadow into the new frame.
         if (boundary) begin
            disp    <= bus.load ? bus.in : shadow;
            pending <= 1'b0;
         end else if (bus.load) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_r    <= 4'hF;
         seg_r   <= 7'h7F;
         dpn_r   <= 1'b1;
         ack_r   <= 1'b0;
         frame_r <= 1'b0;
      end else begin
         an_r    <= off ? 4'hF : ~(4'b0001 << digit);
         seg_r   <= off ? 7'h7F : seg7({12'h000, nib});
         dpn_r   <= off || !bus.dp[digit];
         ack_r   <= boundary && (pending || bus.load);
         frame_r <= boundary;
      end
   end

   assign bus.an    = an_r;
   assign bus.seg   = seg_r;
   assign bus.dp_n  = dpn_r;
   assign bus.ack   = ack_r;
   assign bus.frame = frame_r;
endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboarded bench for seg7_scan: a cycle-indexed reference model pushes expected
// pin states per clock; a negedge monitor pops and compares, plus scan-safety properties.
module tb_seg7_scan;
   localparam int DIV = 8;
   localparam int GUARD = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg7_scan_if b0();
   seg7_scan_if b1();
   assign b1.in    = b0.in;
   assign b1.load  = b0.load;
   assign b1.dp    = b0.dp;
   assign b1.blank = b0.blank;

   seg7_scan #(.DIV(DIV), .GUARD(GUARD), .LZB(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   seg7_scan #(.DIV(DIV), .GUARD(GUARD), .LZB(0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

   typedef struct {
      logic [3:0] an;  logic [6:0] seg;  logic dpn;
      logic [3:0] an1; logic [6:0] seg1; logic dpn1;
      logic ack; logic frame;
   } exp_t;

   exp_t sbq[$];
   int checks = 0, failures = 0;
   logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // reference model: position in scan derived from cycles since reset release
   int t;
   logic [15:0] mdisp, mshadow;
   logic mpend;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         if (failures <= 40) $display("FAIL %s actual=%0h required=%0h (t=%0d)", name, act, req, t);
      end
   endtask

   task automatic step(input logic [15:0] v, input logic ld, input logic [3:0] d, input logic bl);
      exp_t e;
      int pos, dig;
      logic [15:0] upper;
      logic drv, lz, bnd;
      b0.in = v; b0.load = ld; b0.dp = d; b0.blank = bl;
      @(posedge clk);
      pos   = t % DIV;
      dig   = (t / DIV) % 4;
      upper = mdisp >> (4 * dig);
      drv   = (pos >= GUARD);
      lz    = (dig > 0) && (upper == 16'h0);
      e.an   = (!drv || bl || lz) ? 4'hF : ~(4'b0001 << dig);
      e.seg  = (!drv || bl || lz) ? 7'h7F : tbl[upper[3:0]];
      e.dpn  = (!drv || bl || lz) ? 1'b1 : !d[dig];
      e.an1  = (!drv || bl) ? 4'hF : ~(4'b0001 << dig);
      e.seg1 = (!drv || bl) ? 7'h7F : tbl[upper[3:0]];
      e.dpn1 = (!drv || bl) ? 1'b1 : !d[dig];
      bnd     = (dig == 3) && (pos == DIV - 1);
      e.frame = bnd;
      e.ack   = bnd && (mpend || ld);
      if (bnd) begin
         mdisp = ld ? v : mshadow;
         mpend = 1'b0;
      end
      if (ld) begin
         mshadow = v;
         if (!bnd) mpend = 1'b1;
      end
      sbq.push_back(e);
      t++;
      #1;
   endtask

   task automatic idle();
      step(b0.in, 1'b0, b0.dp, b0.blank);
   endtask

   task automatic run_to_frame();
      int n;
      n = 0;
      do begin
         idle();
         n++;
      end while (!b0.frame && n < 40);
      if (!b0.frame) chk("frame_timeout", 0, 1);
   endtask

   task automatic model_reset();
      t = 0; mdisp = '0; mshadow = '0; mpend = 1'b0;
   endtask

   // monitor
   logic [3:0] last_an;
   int gap;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         last_an = 4'hF;
         gap = 0;
      end else if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("an",     b0.an,    e.an);
         chk("seg",    b0.seg,   e.seg);
         chk("dp_n",   b0.dp_n,  e.dpn);
         chk("ack",    b0.ack,   e.ack);
         chk("frame",  b0.frame, e.frame);
         chk("an_nolzb",   b1.an,   e.an1);
         chk("seg_nolzb",  b1.seg,  e.seg1);
         chk("dp_n_nolzb", b1.dp_n, e.dpn1);
         chk("onehot0", $onehot0(~b0.an), 1);
         if (b0.ack) chk("ack_with_frame", b0.frame, 1);
         if (b0.an != 4'hF) begin
            if (last_an != 4'hF && b0.an != last_an) chk("guard_gap", gap >= GUARD, 1);
            last_an = b0.an;
            gap = 0;
         end else begin
            gap++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks, frames;
      rst = 1'b1;
      b0.in = '0; b0.load = 1'b0; b0.dp = '0; b0.blank = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", b0.an, 4'hF);
      chk("rst_seg", b0.seg, 7'h7F);
      chk("rst_dp_n", b0.dp_n, 1);
      chk("rst_ack", b0.ack, 0);
      chk("rst_frame", b0.frame, 0);
      rst = 1'b0;

      // first drive appears three clocks after release
      step(16'h0, 0, 4'h0, 0);
      step(16'h0, 0, 4'h0, 0);
      chk("first_guard_an", b0.an, 4'hF);
      step(16'h0, 0, 4'h0, 0);
      chk("first_drive_an", b0.an, 4'hE);
      chk("first_drive_seg", b0.seg, 7'h40);
      step(16'h0, 0, 4'h0, 0);

      // reset asserted mid-DRIVE takes effect in the same cycle
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_an", b0.an, 4'hF);
      chk("midrst_seg", b0.seg, 7'h7F);
      chk("midrst_dp_n", b0.dp_n, 1);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // 1234 across all four digits
      step(16'h1234, 1, 4'h0, 0);
      run_to_frame();
      chk("ack_1234", b0.ack, 1);
      repeat (3) idle();
      chk("d0_an", b0.an, 4'hE); chk("d0_seg", b0.seg, 7'h19);
      repeat (8) idle();
      chk("d1_an", b0.an, 4'hD); chk("d1_seg", b0.seg, 7'h30);
      repeat (8) idle();
      chk("d2_an", b0.an, 4'hB); chk("d2_seg", b0.seg, 7'h24);
      repeat (8) idle();
      chk("d3_an", b0.an, 4'h7); chk("d3_seg", b0.seg, 7'h79);

      // leading-zero blanking vs. LZB=0
      step(16'h0005, 1, 4'h0, 0);
      run_to_frame();
      repeat (3) idle();
      chk("lz_d0_seg", b0.seg, 7'h12);
      chk("lz_d0_an", b0.an, 4'hE);
      repeat (24) idle();
      chk("lz_d3_an", b0.an, 4'hF);
      chk("nolz_d3_an", b1.an, 4'h7);
      chk("nolz_d3_seg", b1.seg, 7'h40);

      // two loads in one frame: single ack, last wins
      run_to_frame();
      step(16'h1111, 1, 4'h0, 0);
      idle();
      step(16'h2222, 1, 4'h0, 0);
      acks = 0;
      for (int i = 0; i < 40; i++) begin
         idle();
         if (b0.ack) acks++;
      end
      chk("single_ack", acks, 1);
      run_to_frame();
      repeat (3) idle();
      chk("last_wins_seg", b0.seg, 7'h24);

      // load on the boundary cycle bypasses into the starting frame
      while ((t % 32) != 31) idle();
      step(16'hABCD, 1, 4'h0, 0);
      chk("bypass_ack", b0.ack, 1);
      chk("bypass_frame", b0.frame, 1);
      repeat (3) idle();
      chk("bypass_seg", b0.seg, 7'h21);

      // decimal point on digit 2 only
      for (int i = 0; i < 40; i++) begin
         step(b0.in, 0, 4'b0100, 0);
         chk("dp_digit2", !b0.dp_n, b0.an == 4'hB);
      end

      // blank keeps the scan and frame pulses running
      frames = 0;
      for (int i = 0; i < 64; i++) begin
         step(b0.in, 0, 4'b0100, 1);
         chk("blank_an", b0.an, 4'hF);
         if (b0.frame) frames++;
      end
      chk("blank_frames", frames, 2);
      repeat (10) step(b0.in, 0, 4'h0, 0);

      // random traffic
      for (int i = 0; i < 10000; i++)
         step(16'($urandom), $urandom_range(0, 15) == 0, 4'($urandom),
              $urandom_range(0, 9) == 0);

      repeat (2) @(negedge clk);
      chk("queue_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
